// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the default parameter values and the clear-sequencer state encoding
// so the top level and any future users agree on them.
package rf_pkg;

    localparam int DEF_WORD_LEN      = 16;
    localparam int DEF_REG_ADDR_LEN  = 3;
    localparam int DEF_REG_FILE_SIZE = 8;
    localparam int DEF_RD_PORTS      = 2;
    localparam int DEF_WR_PORTS      = 2;
    localparam int DEF_BYPASS        = 1;

    // Clear sequencer: IDLE serves normal traffic, CLEAR walks the array.
    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for the register file.
// Decides which write ports actually land this cycle and flags a
// same-address collision between ports.
//   wr_en    : per-port write enable
//   wr_addr  : packed write addresses, port k at slice k
//   wr_valid : per-port "this write commits" (r0 writes and losers removed)
//   conflict : two or more enabled ports target the same non-zero address
module rf_wr_arbiter #(
    parameter int p_REG_ADDR_LEN = 3,
    parameter int p_WR_PORTS     = 2
) (
    input  logic [p_WR_PORTS-1:0]                wr_en,
    input  logic [p_WR_PORTS*p_REG_ADDR_LEN-1:0] wr_addr,
    output logic [p_WR_PORTS-1:0]                wr_valid,
    output logic                                 conflict
);

    // A port survives unless a higher-index port hits the same address,
    // which leaves at most one valid writer per register.
    always_comb begin
        wr_valid = '0;
        conflict = 1'b0;
        for (int k = 0; k < p_WR_PORTS; k++) begin
            wr_valid[k] = wr_en[k] &&
                          (wr_addr[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN] != '0);
            for (int j = k + 1; j < p_WR_PORTS; j++) begin
                if (wr_valid[k] && wr_en[j] &&
                    (wr_addr[j*p_REG_ADDR_LEN +: p_REG_ADDR_LEN] ==
                     wr_addr[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN])) begin
                    wr_valid[k] = 1'b0;
                    conflict    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired-zero r0, optional write-to-read
// forwarding and a sequenced clear engine.
//   i_clk / i_rst  : clock, async active-high reset (starts a clear)
//   i_rd_addr      : packed read addresses -> o_rd_data (combinational)
//   i_wr_en/addr/data : packed write ports, higher index wins on collision
//   i_clr          : request a clear of r1..r(N-1)
//   o_busy         : clear in progress, writes ignored and reads return 0
//   o_wr_conflict  : one-cycle pulse after a same-address multi-port write
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int p_WORD_LEN      = DEF_WORD_LEN,
    parameter int p_REG_ADDR_LEN  = DEF_REG_ADDR_LEN,
    parameter int p_REG_FILE_SIZE = DEF_REG_FILE_SIZE,
    parameter int p_RD_PORTS      = DEF_RD_PORTS,
    parameter int p_WR_PORTS      = DEF_WR_PORTS,
    parameter int p_BYPASS        = DEF_BYPASS
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [p_RD_PORTS*p_REG_ADDR_LEN-1:0] i_rd_addr,
    output logic [p_RD_PORTS*p_WORD_LEN-1:0]     o_rd_data,
    input  logic [p_WR_PORTS-1:0]                i_wr_en,
    input  logic [p_WR_PORTS*p_REG_ADDR_LEN-1:0] i_wr_addr,
    input  logic [p_WR_PORTS*p_WORD_LEN-1:0]     i_wr_data,
    input  logic                                 i_clr,
    output logic                                 o_busy,
    output logic                                 o_wr_conflict
);

    logic [p_WORD_LEN-1:0]     mem [p_REG_FILE_SIZE];
    clr_state_t                state, state_next;
    logic [p_REG_ADDR_LEN-1:0] ptr, ptr_next;
    logic [p_WR_PORTS-1:0]     wr_valid;
    logic                      conflict;
    logic                      busy;
    logic                      write_allowed;

    assign busy   = (state == CLR_CLEAR);
    assign o_busy = busy;

    // A clear request in IDLE beats any write issued alongside it.
    assign write_allowed = !busy && !i_clr;

    rf_wr_arbiter #(
        .p_REG_ADDR_LEN (p_REG_ADDR_LEN),
        .p_WR_PORTS     (p_WR_PORTS)
    ) u_arbiter (
        .wr_en    (i_wr_en),
        .wr_addr  (i_wr_addr),
        .wr_valid (wr_valid),
        .conflict (conflict)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= CLR_CLEAR;
            ptr           <= p_REG_ADDR_LEN'(1);
            o_wr_conflict <= 1'b0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            o_wr_conflict <= conflict && write_allowed;
        end
    end

    // r0 is never stored, so the walk starts at 1 and stops at the top.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLR_IDLE: begin
                if (i_clr) begin
                    state_next = CLR_CLEAR;
                    ptr_next   = p_REG_ADDR_LEN'(1);
                end
            end
            CLR_CLEAR: begin
                ptr_next = ptr + p_REG_ADDR_LEN'(1);
                if (ptr == p_REG_ADDR_LEN'(p_REG_FILE_SIZE - 1))
                    state_next = CLR_IDLE;
            end
            default: begin
                state_next = CLR_CLEAR;
                ptr_next   = p_REG_ADDR_LEN'(1);
            end
        endcase
    end

    // Storage has no reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else if (write_allowed) begin
            for (int k = 0; k < p_WR_PORTS; k++) begin
                if (wr_valid[k])
                    mem[i_wr_addr[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN]] <=
                        i_wr_data[k*p_WORD_LEN +: p_WORD_LEN];
            end
        end
    end

    for (genvar r = 0; r < p_RD_PORTS; r++) begin : g_rd
        logic [p_REG_ADDR_LEN-1:0] addr;
        logic [p_WORD_LEN-1:0]     fwd_data;
        logic                      fwd_hit;
        logic [p_WORD_LEN-1:0]     rd_data;

        assign addr = i_rd_addr[r*p_REG_ADDR_LEN +: p_REG_ADDR_LEN];

        // wr_valid already excludes r0 and losing ports, so any hit is the winner.
        always_comb begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
            if (p_BYPASS != 0) begin
                for (int k = 0; k < p_WR_PORTS; k++) begin
                    if (wr_valid[k] &&
                        (i_wr_addr[k*p_REG_ADDR_LEN +: p_REG_ADDR_LEN] == addr)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = i_wr_data[k*p_WORD_LEN +: p_WORD_LEN];
                    end
                end
            end
        end

        always_comb begin
            if (busy || (addr == '0))
                rd_data = '0;
            else if (fwd_hit)
                rd_data = fwd_data;
            else
                rd_data = mem[addr];
        end

        assign o_rd_data[r*p_WORD_LEN +: p_WORD_LEN] = rd_data;
    end

endmodule
